// File: rtl/case_4_mul_pipe_sat_pkg.sv
// Shared types and the wrap/saturate helper for the pipelined multiplier.
// Widths are handled at MAX_PW bits so one function serves every parameter set.
package case_4_mul_pkg;

    localparam int MAX_STAGE = 4;
    localparam int MAX_PW    = 64;

    typedef struct packed {
        logic is_signed;
        logic sat_en;
    } mode_t;

    typedef struct packed {
        logic              ovf;
        logic [MAX_PW-1:0] dout;
    } clamp_t;

    // p is the full product already extended to MAX_PW bits in its own signedness;
    // the caller keeps the low dw bits of the returned dout.
    function automatic clamp_t mul_clamp(input logic [MAX_PW-1:0] p,
                                         input mode_t             mode,
                                         input int unsigned       dw);
        logic [MAX_PW-1:0] smask;
        logic [MAX_PW-1:0] umask;
        logic              sovf;
        logic              uovf;
        clamp_t            res;
        smask    = ~((MAX_PW'(1) << (dw - 1)) - MAX_PW'(1));
        umask    = ~((MAX_PW'(1) << dw) - MAX_PW'(1));
        sovf     = ((p & smask) != '0) && ((p & smask) != smask);
        uovf     = (p & umask) != '0;
        res.ovf  = mode.is_signed ? sovf : uovf;
        res.dout = p;
        if (mode.sat_en && res.ovf) begin
            if (mode.is_signed) res.dout = p[MAX_PW-1] ? smask : ~smask;
            else                res.dout = ~umask;
        end
        return res;
    endfunction

endpackage

// File: rtl/case_4_mul_pipe_sat_if.sv
// Operand/result handshake bundle between the HLS producer/consumer and the multiplier.
interface case_4_mul_pipe_sat_if #(
    parameter int din0_WIDTH = 9,
    parameter int din1_WIDTH = 9,
    parameter int dout_WIDTH = 9
);
    logic                  in_valid;
    logic                  in_ready;
    logic [din0_WIDTH-1:0] din0;
    logic [din1_WIDTH-1:0] din1;
    logic                  is_signed;
    logic                  sat_en;
    logic                  out_valid;
    logic                  out_ready;
    logic [dout_WIDTH-1:0] dout;
    logic                  ovf;
    logic                  busy;

    modport master (
        output in_valid, din0, din1, is_signed, sat_en, out_ready,
        input  in_ready, out_valid, dout, ovf, busy
    );

    modport slave (
        input  in_valid, din0, din1, is_signed, sat_en, out_ready,
        output in_ready, out_valid, dout, ovf, busy
    );
endinterface

// File: rtl/case_4_mul_pipe_sat_slice.sv
// One register slice of the result pipeline: {valid, dout, ovf} plus its advance logic.
module case_4_mul_pipe_slice #(
    parameter int DW = 9
) (
    input  logic          ap_clk,
    input  logic          ap_rst_n,
    input  logic          up_valid_i,
    input  logic [DW-1:0] up_dout_i,
    input  logic          up_ovf_i,
    input  logic          dn_ready_i,
    output logic          ready_o,
    output logic          valid_o,
    output logic [DW-1:0] dout_o,
    output logic          ovf_o
);
    logic          valid_q, valid_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          ovf_q, ovf_d;

    // An empty slice always loads, so bubbles collapse as data moves forward.
    assign ready_o = !valid_q || dn_ready_i;

    always_comb begin
        valid_d = valid_q;
        dout_d  = dout_q;
        ovf_d   = ovf_q;
        if (ready_o) begin
            valid_d = up_valid_i;
            if (up_valid_i) begin
                dout_d = up_dout_i;
                ovf_d  = up_ovf_i;
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            valid_q <= 1'b0;
            dout_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            dout_q  <= dout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign valid_o = valid_q;
    assign dout_o  = dout_q;
    assign ovf_o   = ovf_q;
endmodule

// File: rtl/case_4_mul_pipe_sat.sv
// Pipelined signed/unsigned multiplier with wrap or saturate output and overflow flag.
// The product is clamped combinationally and then carried through NUM_STAGE slices.
module case_4_mul_pipe_sat
    import case_4_mul_pkg::*;
#(
    parameter int din0_WIDTH = 9,
    parameter int din1_WIDTH = 9,
    parameter int dout_WIDTH = 9,
    parameter int NUM_STAGE  = 2
) (
    input logic                  ap_clk,
    input logic                  ap_rst_n,
    case_4_mul_pipe_sat_if.slave bus
);
    localparam int PW = din0_WIDTH + din1_WIDTH;

    mode_t                  mode;
    logic [PW-1:0]          a_ext;
    logic [PW-1:0]          b_ext;
    logic [PW-1:0]          prod;
    logic [MAX_PW-1:0]      p_ext;
    clamp_t                 clamp;
    logic [NUM_STAGE-1:0]   valid_all;

    // Extending both operands to PW bits makes the low PW bits of the product exact in either mode.
    always_comb begin
        mode.is_signed = bus.is_signed;
        mode.sat_en    = bus.sat_en;
        a_ext = {PW{mode.is_signed & bus.din0[din0_WIDTH-1]}};
        a_ext[din0_WIDTH-1:0] = bus.din0;
        b_ext = {PW{mode.is_signed & bus.din1[din1_WIDTH-1]}};
        b_ext[din1_WIDTH-1:0] = bus.din1;
        prod  = a_ext * b_ext;
        p_ext = {MAX_PW{mode.is_signed & prod[PW-1]}};
        p_ext[PW-1:0] = prod;
        clamp = mul_clamp(p_ext, mode, dout_WIDTH);
    end

    if (dout_WIDTH < MAX_PW) begin : g_trunc
        logic unused_hi;
        assign unused_hi = ^clamp.dout[MAX_PW-1:dout_WIDTH];
    end

    for (genvar k = 0; k < NUM_STAGE; k++) begin : g_slice
        logic                  up_valid, up_ovf, dn_ready;
        logic                  ready, valid, ovf;
        logic [dout_WIDTH-1:0] up_dout, dout;

        if (k == 0) begin : g_head
            assign up_valid = bus.in_valid;
            assign up_dout  = clamp.dout[dout_WIDTH-1:0];
            assign up_ovf   = clamp.ovf;
        end else begin : g_body
            assign up_valid = g_slice[k-1].valid;
            assign up_dout  = g_slice[k-1].dout;
            assign up_ovf   = g_slice[k-1].ovf;
        end

        if (k == NUM_STAGE - 1) begin : g_tail
            assign dn_ready = bus.out_ready;
        end else begin : g_inner
            assign dn_ready = g_slice[k+1].ready;
        end

        case_4_mul_pipe_slice #(.DW(dout_WIDTH)) u_slice (
            .ap_clk     (ap_clk),
            .ap_rst_n   (ap_rst_n),
            .up_valid_i (up_valid),
            .up_dout_i  (up_dout),
            .up_ovf_i   (up_ovf),
            .dn_ready_i (dn_ready),
            .ready_o    (ready),
            .valid_o    (valid),
            .dout_o     (dout),
            .ovf_o      (ovf)
        );

        assign valid_all[k] = valid;
    end

    assign bus.in_ready  = g_slice[0].ready;
    assign bus.out_valid = g_slice[NUM_STAGE-1].valid;
    assign bus.dout      = g_slice[NUM_STAGE-1].dout;
    assign bus.ovf       = g_slice[NUM_STAGE-1].ovf;
    assign bus.busy      = |valid_all;
endmodule

// File: tb/tb_case_4_mul_pipe_sat.sv
// Scoreboard bench: directed cases on a default and a 3-stage instance, plus
// randomized traffic on four width/depth variants checked against an integer model.
module tb_case_4_mul_pipe_sat;

    typedef struct {
        logic [63:0] dout;
        logic        ovf;
    } exp_t;

    localparam int N_RND = 2500;

    int   vectors     = 0;
    int   miscompares = 0;
    logic ap_clk      = 1'b0;
    logic rst_n       = 1'b1;
    logic rst_n_dir   = 1'b1;

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Range-based model: exact integer product, then compare against the representable interval.
    function automatic exp_t ref_model(input logic [63:0] a_raw, input logic [63:0] b_raw,
                                       input int w0, input int w1, input int dw,
                                       input bit sg, input bit sat);
        logic signed [127:0] a, b, p, lo, hi, r, one;
        exp_t e;
        one = 128'sd1;
        a = $signed({64'd0, a_raw});
        b = $signed({64'd0, b_raw});
        if (sg && a_raw[w0-1]) a = a - (one <<< w0);
        if (sg && b_raw[w1-1]) b = b - (one <<< w1);
        p = a * b;
        if (sg) begin
            hi = (one <<< (dw - 1)) - one;
            lo = -(one <<< (dw - 1));
        end else begin
            hi = (one <<< dw) - one;
            lo = '0;
        end
        e.ovf = (p < lo) || (p > hi);
        r = p;
        if (sat && p < lo) r = lo;
        if (sat && p > hi) r = hi;
        r = r & ((one <<< dw) - one);
        e.dout = r[63:0];
        return e;
    endfunction

    function automatic logic [63:0] rnd_operand(input int w);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        case ($urandom_range(0, 4))
            0:       return 64'd0;
            1:       return mask;
            2:       return 64'd1 << (w - 1);
            default: return {$urandom(), $urandom()} & mask;
        endcase
    endfunction

    function automatic int rw0(input int g);
        case (g) 0: return 5;  1: return 9; 2: return 16; default: return 32; endcase
    endfunction
    function automatic int rw1(input int g);
        case (g) 0: return 7;  1: return 9; 2: return 13; default: return 31; endcase
    endfunction
    function automatic int rdw(input int g);
        case (g) 0: return 6;  1: return 9; 2: return 20; default: return 40; endcase
    endfunction

    // ---------------- directed instances ----------------
    case_4_mul_pipe_sat_if #(.din0_WIDTH(9), .din1_WIDTH(9), .dout_WIDTH(9)) bus_dir ();
    case_4_mul_pipe_sat_if #(.din0_WIDTH(9), .din1_WIDTH(9), .dout_WIDTH(9)) bus_bp ();

    case_4_mul_pipe_sat #(.din0_WIDTH(9), .din1_WIDTH(9), .dout_WIDTH(9), .NUM_STAGE(2)) u_dir (
        .ap_clk(ap_clk), .ap_rst_n(rst_n_dir), .bus(bus_dir));
    case_4_mul_pipe_sat #(.din0_WIDTH(9), .din1_WIDTH(9), .dout_WIDTH(9), .NUM_STAGE(3)) u_bp (
        .ap_clk(ap_clk), .ap_rst_n(rst_n), .bus(bus_bp));

    exp_t q_dir[$];
    exp_t q_bp[$];
    int   got_bp = 0;

    initial begin : mon_dir
        exp_t e;
        forever begin
            @(negedge ap_clk); #1;
            if (bus_dir.out_valid && bus_dir.out_ready) begin
                if (q_dir.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL dir_extra: got output 0x%0h, expected none", bus_dir.dout);
                end else begin
                    e = q_dir.pop_front();
                    check("dir_dout", 64'(bus_dir.dout), e.dout);
                    check("dir_ovf", 64'(bus_dir.ovf), 64'(e.ovf));
                end
            end
        end
    end

    initial begin : mon_bp
        exp_t e;
        forever begin
            @(negedge ap_clk); #1;
            if (bus_bp.out_valid && bus_bp.out_ready) begin
                if (q_bp.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL bp_extra: got output 0x%0h, expected none", bus_bp.dout);
                end else begin
                    e = q_bp.pop_front();
                    check("bp_dout", 64'(bus_bp.dout), e.dout);
                    check("bp_ovf", 64'(bus_bp.ovf), 64'(e.ovf));
                    got_bp++;
                end
            end
        end
    end

    // Called at a negedge; leaves the caller at the negedge after the accepting edge.
    task automatic send_dir(input logic [8:0] a, input logic [8:0] b, input bit sg, input bit sat,
                            input logic [63:0] exp_dout, input bit exp_ovf);
        exp_t e;
        int   n = 0;
        bus_dir.in_valid  = 1'b1;
        bus_dir.din0      = a;
        bus_dir.din1      = b;
        bus_dir.is_signed = sg;
        bus_dir.sat_en    = sat;
        #1;
        while (!bus_dir.in_ready && n < 20) begin
            @(negedge ap_clk); #1; n++;
        end
        check("dir_in_ready", 64'(bus_dir.in_ready), 64'd1);
        e.dout = exp_dout;
        e.ovf  = exp_ovf;
        q_dir.push_back(e);
        @(negedge ap_clk);
        bus_dir.in_valid = 1'b0;
    endtask

    // Two-stage instance: result must be absent one edge after accept, present after the next.
    task automatic check_latency_dir();
        #1;
        check("lat_early", 64'(bus_dir.out_valid), 64'd0);
        @(negedge ap_clk); #1;
        check("lat_out_valid", 64'(bus_dir.out_valid), 64'd1);
    endtask

    task automatic drain_dir();
        int n = 0;
        while ((q_dir.size() != 0 || bus_dir.busy) && n < 50) begin
            @(negedge ap_clk); #1; n++;
        end
        check("dir_drain", 64'(q_dir.size()), 64'd0);
    endtask

    // ---------------- random instances ----------------
    for (genvar g = 0; g < 4; g++) begin : g_rnd
        localparam int W0 = rw0(g);
        localparam int W1 = rw1(g);
        localparam int DW = rdw(g);
        localparam int NS = g + 1;

        case_4_mul_pipe_sat_if #(.din0_WIDTH(W0), .din1_WIDTH(W1), .dout_WIDTH(DW)) bus ();
        case_4_mul_pipe_sat #(.din0_WIDTH(W0), .din1_WIDTH(W1), .dout_WIDTH(DW), .NUM_STAGE(NS)) u_dut (
            .ap_clk(ap_clk), .ap_rst_n(rst_n), .bus(bus));

        exp_t q[$];
        int   sent = 0;
        int   got  = 0;

        initial begin : drv
            logic [63:0] a, b;
            bit          sg, sat;
            int          cyc = 0;
            bus.in_valid  = 1'b0;
            bus.din0      = '0;
            bus.din1      = '0;
            bus.is_signed = 1'b0;
            bus.sat_en    = 1'b0;
            wait (rst_n === 1'b0);
            wait (rst_n === 1'b1);
            @(negedge ap_clk);
            while (sent < N_RND && cyc < 40000) begin
                a   = rnd_operand(W0);
                b   = rnd_operand(W1);
                sg  = 1'($urandom_range(0, 1));
                sat = 1'($urandom_range(0, 1));
                bus.in_valid  = ($urandom_range(0, 3) != 0);
                bus.din0      = W0'(a);
                bus.din1      = W1'(b);
                bus.is_signed = sg;
                bus.sat_en    = sat;
                #1;
                if (bus.in_valid && bus.in_ready) begin
                    q.push_back(ref_model(a, b, W0, W1, DW, sg, sat));
                    sent++;
                end
                @(negedge ap_clk);
                cyc++;
            end
            bus.in_valid = 1'b0;
        end

        initial begin : mon
            exp_t        e;
            logic        held_v = 1'b0;
            logic [63:0] held_d = '0;
            logic        held_o = 1'b0;
            bus.out_ready = 1'b0;
            wait (rst_n === 1'b0);
            wait (rst_n === 1'b1);
            forever begin
                @(negedge ap_clk);
                bus.out_ready = ($urandom_range(0, 3) != 0);
                #1;
                if (held_v) begin
                    check("rnd_hold_valid", 64'(bus.out_valid), 64'd1);
                    check("rnd_hold_dout", 64'(bus.dout), held_d);
                    check("rnd_hold_ovf", 64'(bus.ovf), 64'(held_o));
                end
                held_v = bus.out_valid && !bus.out_ready;
                held_d = 64'(bus.dout);
                held_o = bus.ovf;
                if (bus.out_valid && bus.out_ready) begin
                    if (q.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL rnd_extra: stage %0d got output 0x%0h, expected none", NS, bus.dout);
                    end else begin
                        e = q.pop_front();
                        check("rnd_dout", 64'(bus.dout), e.dout);
                        check("rnd_ovf", 64'(bus.ovf), 64'(e.ovf));
                        got++;
                    end
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin : main
        logic [8:0]  bp_a [5];
        logic [8:0]  bp_b [5];
        bit          bp_s [5];
        bit          bp_t [5];
        int          nxt;
        int          n;
        logic        held_v;
        logic [63:0] held_d;

        bus_dir.in_valid = 1'b0; bus_dir.din0 = '0; bus_dir.din1 = '0;
        bus_dir.is_signed = 1'b0; bus_dir.sat_en = 1'b0; bus_dir.out_ready = 1'b1;
        bus_bp.in_valid = 1'b0; bus_bp.din0 = '0; bus_bp.din1 = '0;
        bus_bp.is_signed = 1'b0; bus_bp.sat_en = 1'b0; bus_bp.out_ready = 1'b0;

        #1;
        rst_n     = 1'b0;
        rst_n_dir = 1'b0;
        #1;
        check("rst_out_valid", 64'(bus_dir.out_valid), 64'd0);
        check("rst_dout", 64'(bus_dir.dout), 64'd0);
        check("rst_ovf", 64'(bus_dir.ovf), 64'd0);
        check("rst_busy", 64'(bus_dir.busy), 64'd0);
        check("rst_in_ready", 64'(bus_dir.in_ready), 64'd1);
        repeat (3) @(negedge ap_clk);
        rst_n     = 1'b1;
        rst_n_dir = 1'b1;
        @(negedge ap_clk);

        // Signed wrap with nominal latency, then the overflow corners back to back.
        send_dir(9'd12, 9'h1F6, 1'b1, 1'b0, 64'h188, 1'b0);
        check_latency_dir();
        drain_dir();
        @(negedge ap_clk);
        send_dir(9'h100, 9'h100, 1'b1, 1'b0, 64'h000, 1'b1);
        send_dir(9'h100, 9'h100, 1'b1, 1'b1, 64'h0FF, 1'b1);
        send_dir(9'h1FF, 9'h1FF, 1'b0, 1'b0, 64'h001, 1'b1);
        send_dir(9'h1FF, 9'h1FF, 1'b0, 1'b1, 64'h1FF, 1'b1);
        send_dir(9'h064, 9'h1F9, 1'b1, 1'b0, 64'h144, 1'b1);
        send_dir(9'h064, 9'h1F9, 1'b1, 1'b1, 64'h100, 1'b1);
        drain_dir();

        // Async reset with two transactions held in flight.
        @(negedge ap_clk);
        bus_dir.out_ready = 1'b0;
        send_dir(9'd3, 9'd5, 1'b0, 1'b0, 64'd15, 1'b0);
        send_dir(9'd7, 9'd2, 1'b0, 1'b0, 64'd14, 1'b0);
        #2;
        check("inflight_busy", 64'(bus_dir.busy), 64'd1);
        rst_n_dir = 1'b0;
        #1;
        check("arst_out_valid", 64'(bus_dir.out_valid), 64'd0);
        check("arst_dout", 64'(bus_dir.dout), 64'd0);
        check("arst_ovf", 64'(bus_dir.ovf), 64'd0);
        check("arst_busy", 64'(bus_dir.busy), 64'd0);
        check("arst_in_ready", 64'(bus_dir.in_ready), 64'd1);
        q_dir.delete();
        bus_dir.out_ready = 1'b1;
        repeat (2) @(negedge ap_clk);
        rst_n_dir = 1'b1;
        repeat (3) begin
            @(negedge ap_clk); #1;
            check("arst_no_stale", 64'(bus_dir.out_valid), 64'd0);
        end
        send_dir(9'd6, 9'd7, 1'b0, 1'b0, 64'd42, 1'b0);
        check_latency_dir();
        drain_dir();

        // Backpressure on the three-stage instance.
        for (int i = 0; i < 5; i++) begin
            bp_a[i] = 9'($urandom);
            bp_b[i] = 9'($urandom);
            bp_s[i] = 1'($urandom_range(0, 1));
            bp_t[i] = 1'($urandom_range(0, 1));
        end
        nxt    = 0;
        held_v = 1'b0;
        held_d = '0;
        @(negedge ap_clk);
        for (int c = 0; c < 6; c++) begin
            bus_bp.in_valid = (nxt < 5);
            if (nxt < 5) begin
                bus_bp.din0 = bp_a[nxt]; bus_bp.din1 = bp_b[nxt];
                bus_bp.is_signed = bp_s[nxt]; bus_bp.sat_en = bp_t[nxt];
            end
            #1;
            if (c < 5) check("bp_in_ready", 64'(bus_bp.in_ready), 64'(c < 3));
            if (bus_bp.in_valid && bus_bp.in_ready) begin
                q_bp.push_back(ref_model(64'(bp_a[nxt]), 64'(bp_b[nxt]), 9, 9, 9, bp_s[nxt], bp_t[nxt]));
                nxt++;
            end
            if (bus_bp.out_valid) begin
                if (held_v) check("bp_hold_dout", 64'(bus_bp.dout), held_d);
                held_v = 1'b1;
                held_d = 64'(bus_bp.dout);
            end
            @(negedge ap_clk);
        end
        check("bp_accepts", 64'(nxt), 64'd3);
        check("bp_busy", 64'(bus_bp.busy), 64'd1);
        bus_bp.out_ready = 1'b1;
        n = 0;
        while (nxt < 5 && n < 30) begin
            bus_bp.in_valid = 1'b1;
            bus_bp.din0 = bp_a[nxt]; bus_bp.din1 = bp_b[nxt];
            bus_bp.is_signed = bp_s[nxt]; bus_bp.sat_en = bp_t[nxt];
            #1;
            if (bus_bp.in_ready) begin
                q_bp.push_back(ref_model(64'(bp_a[nxt]), 64'(bp_b[nxt]), 9, 9, 9, bp_s[nxt], bp_t[nxt]));
                nxt++;
            end
            @(negedge ap_clk);
            n++;
        end
        bus_bp.in_valid = 1'b0;
        n = 0;
        while ((q_bp.size() != 0 || bus_bp.busy) && n < 50) begin
            @(negedge ap_clk); #1; n++;
        end
        check("bp_received", 64'(got_bp), 64'd5);
        check("bp_queue_empty", 64'(q_bp.size()), 64'd0);

        // Wait for the random runs, bounded.
        n = 0;
        while (!(g_rnd[0].got >= N_RND && g_rnd[1].got >= N_RND &&
                 g_rnd[2].got >= N_RND && g_rnd[3].got >= N_RND) && n < 60000) begin
            @(negedge ap_clk); n++;
        end
        check("rnd_count_s1", 64'(g_rnd[0].got), 64'(N_RND));
        check("rnd_count_s2", 64'(g_rnd[1].got), 64'(N_RND));
        check("rnd_count_s3", 64'(g_rnd[2].got), 64'(N_RND));
        check("rnd_count_s4", 64'(g_rnd[3].got), 64'(N_RND));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
